// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding, board timing defaults and helpers for key inputs
//
// Package key_pkg: imported by key_debounce and the key-related sub-modules.
//   key_state_e          : 2-bit debouncer state encoding (UP / DOWN_WAIT / HELD / UP_WAIT)
//   DEF_*_CYCLES         : default timing for a 50 MHz board (20 ms debounce, 1 s long, 200 ms repeat)
//   cnt_width / max_int  : counter sizing helpers
package key_pkg;

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_DOWN_WAIT = 2'd1,
    ST_HELD      = 2'd2,
    ST_UP_WAIT   = 2'd3
  } key_state_e;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int DEF_LONG_CYCLES     = CLK_HZ;       // 1 s
  localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;   // 200 ms

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - raw key pin and conditioned key outputs bundled as one interface
//
// Signals:
//   key         : raw key pin, asynchronous to the consumer clock
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse on an accepted press
//   key_release : one-cycle pulse on an accepted release
//   key_long    : one-cycle long-press / repeat pulse
// Modports:
//   master : the debouncer (reads key, drives the conditioned outputs)
//   slave  : the pin driver / consumer side
interface key_debounce_if;

  logic key;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    input  key,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );

  modport slave (
    output key,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

endinterface

// File: rtl/key_debounce_sync.sv
// rtl/key_debounce_sync.sv - two-flop synchroniser with configurable reset value
//
// Module key_sync, reusable for any switch or key input.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d_i   : asynchronous input
//   q_o   : synchronised output (two clk edges of latency)
module key_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser and debouncer with press/release/long pulses
//
// Optional feature macro: KEY_LONG_PRESS_EN (long-press and auto-repeat pulses on key_long).
// Without it key_long is tied to 0; the port list is the same in both builds.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   kif   : key_debounce_if.master (key in; key_level/key_press/key_release/key_long out)
// Parameters:
//   DEBOUNCE_CYCLES : cycles the synchronised input must hold steady to accept an edge (>= 1)
//   ACTIVE_LOW      : 1 when the raw pin reads 0 while pressed
//   LONG_CYCLES     : held cycles before the first long pulse
//   REPEAT_CYCLES   : cycles between repeat pulses while held
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic            clk,
  input logic            rst_n,
  key_debounce_if.master kif
);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_debounce: cycle parameters must be >= 1");
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int CNT_W = cnt_width(max_int(DEBOUNCE_CYCLES, max_int(LONG_CYCLES, REPEAT_CYCLES)));
`else
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
`endif

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Press side compares before the increment so the press lands one edge
  // earlier than the release; this keeps a pressed level up >= DEBOUNCE_CYCLES+1.
  localparam logic [CNT_W-1:0] DB_PRE    = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam bit               DB_SINGLE = (DEBOUNCE_CYCLES == 1);

  logic       key_sync_s;
  logic       k_s;          // synchronised key, 1 = pressed

  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  key_sync #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kif.key),
    .q_o   (key_sync_s)
  );

  assign k_s = key_sync_s ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_UP: begin
          if (k_s) begin
            cnt_q <= '0;
            if (DB_SINGLE) begin
              state_q <= ST_HELD;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              state_q <= ST_DOWN_WAIT;
            end
          end
        end
        ST_DOWN_WAIT: begin
          if (!k_s) begin
            state_q <= ST_UP;
            cnt_q   <= '0;
          end else if (cnt_q == DB_PRE) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!k_s) begin
            state_q <= ST_UP_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_UP_WAIT: begin
          if (k_s) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_UP;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] lcnt_q;
  logic             rep_q;    // first long pulse already issued this hold
  logic             long_q;

  // Counts only while HELD; a bounce through UP_WAIT freezes it, any other
  // state clears it so the next hold starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      rep_q  <= 1'b0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == ST_HELD) begin
        if ((!rep_q && lcnt_q == LONG_LAST) || (rep_q && lcnt_q == REP_LAST)) begin
          long_q <= 1'b1;
          lcnt_q <= '0;
          rep_q  <= 1'b1;
        end else begin
          lcnt_q <= lcnt_q + CNT_ONE;
        end
      end else if (state_q != ST_UP_WAIT) begin
        lcnt_q <= '0;
        rep_q  <= 1'b0;
      end
    end
  end

  assign kif.key_long = long_q;
`else
  assign kif.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce (table vectors plus corner sequences)
module tb_key_debounce;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  key_debounce_if kif ();

  key_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1'b1),
    .LONG_CYCLES     (LG),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic key;
    logic lvl;
    logic prs;
    logic rel;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] outs();
    return {kif.key_level, kif.key_press, kif.key_release, kif.key_long};
  endfunction

  task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (level,press,release,long)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Add n rows with constant key and level, no pulses.
  task automatic add(input logic k, input int n, input logic l);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.key = k; v.lvl = l; v.prs = 1'b0; v.rel = 1'b0;
      vecs.push_back(v);
    end
  endtask

  task automatic add_pulse(input logic k, input logic l, input logic p, input logic r);
    vec_t v;
    v.key = k; v.lvl = l; v.prs = p; v.rel = r;
    vecs.push_back(v);
  endtask

  // Release the key and wait (bounded) for the debounced level to drop.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    kif.key = 1'b1;
    while (kif.key_level !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    check_bits(name, {3'b000, kif.key_level}, 4'b0000);
    repeat (4) tick();
  endtask

  // Pulse sanity on every cycle out of reset: press/release never together,
  // and neither lasts more than one cycle.
  logic prev_press = 1'b0;
  logic prev_rel   = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check_bits("pulse_shape",
                 {1'b0, kif.key_press & kif.key_release,
                  kif.key_press & prev_press, kif.key_release & prev_rel}, 4'b0000);
    end
    prev_press <= kif.key_press;
    prev_rel   <= kif.key_release;
  end

  initial begin
    int hit;
    int npress;
    int nlong;
    int longs[$];

    // Reset with key pressed: everything low.
    kif.key = 1'b0;
    rst_n   = 1'b0;
    repeat (3) tick();
    check_bits("reset_outputs", outs(), 4'b0000);

    // Releasing reset with key still pressed debounces a fresh press at E+5.
    rst_n  = 1'b1;
    hit    = -1;
    npress = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (kif.key_press === 1'b1) begin
        npress++;
        if (hit < 0) hit = i;
      end
    end
    check_int("reset_press_edge", hit, 5);
    check_int("reset_press_count", npress, 1);
    check_bits("reset_press_level", {3'b000, kif.key_level}, 4'b0001);
    wait_idle("reset_idle");

    // Clean press / release.
    add(1'b0, 5, 1'b0);
    add_pulse(1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 2, 1'b1);
    add(1'b1, 6, 1'b1);
    add_pulse(1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1, 1'b0);
    // Bounce rejection: low 3, high 1, five times.
    for (int r = 0; r < 5; r++) begin
      add(1'b0, 3, 1'b0);
      add(1'b1, 1, 1'b0);
    end
    add(1'b1, 4, 1'b0);
    // Press, then a 2-cycle release glitch while held, then a real release.
    add(1'b0, 5, 1'b0);
    add_pulse(1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 2, 1'b1);
    add(1'b1, 2, 1'b1);
    add(1'b0, 4, 1'b1);
    add(1'b1, 6, 1'b1);
    add_pulse(1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1, 1'b0);

    foreach (vecs[i]) begin
      kif.key = vecs[i].key;
      tick();
      check_bits($sformatf("vec%0d", i), outs(),
                 {vecs[i].lvl, vecs[i].prs, vecs[i].rel, 1'b0});
    end

    // Reset in DOWN_WAIT (count 2): aborted press yields nothing.
    kif.key = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bits($sformatf("abort_pre%0d", i), outs(), 4'b0000);
    end
    rst_n = 1'b0;
    #1;
    check_bits("abort_in_reset", outs(), 4'b0000);
    tick();
    check_bits("abort_reset_edge", outs(), 4'b0000);
    rst_n = 1'b1;

    // Fresh press after reset, held 40 cycles past HELD entry for long pulses.
    hit    = -1;
    npress = 0;
    for (int i = 0; i < 46; i++) begin
      tick();
      if (kif.key_press === 1'b1) begin
        npress++;
        if (hit < 0) hit = i;
      end
      if (kif.key_long === 1'b1) longs.push_back(i - hit);
    end
    check_int("rearm_press_edge", hit, 5);
    check_int("rearm_press_count", npress, 1);
    check_bits("rearm_level", {3'b000, kif.key_level}, 4'b0001);
    nlong = longs.size();
`ifdef KEY_LONG_PRESS_EN
    check_int("long_count", nlong, 3);
    if (nlong == 3) begin
      check_int("long_first", longs[0], LG);
      check_int("long_rep1", longs[1], LG + RP);
      check_int("long_rep2", longs[2], LG + 2 * RP);
    end
`else
    check_int("long_count_disabled", nlong, 0);
`endif
    wait_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
